hazard_scoreboard: RTL and testbench

//  Parametrised successor to the decode-stage data-hazard detector. It holds a shift-register scoreboard of
//  in-flight destination tags for the EX/MEM/WB stages. Each cycle it raises a stall for RAW hazards and,
//  in forwarding mode, emits registered per-source bypass selects aligned to the instruction entering EX.

---
 rtl/hazard_pkg.sv | 52 +++++
 rtl/hazard_field_decode.sv | 91 +++++++++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard: ISA opcodes,
// bypass-select encodings and the select-priority helper.
package hazard_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_ROLI  = 5'b10100;
  localparam logic [4:0] OP_SLLI  = 5'b10101;
  localparam logic [4:0] OP_RORI  = 5'b10110;
  localparam logic [4:0] OP_SRLI  = 5'b10111;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_SHF   = 5'b11010;
  localparam logic [4:0] OP_ALU   = 5'b11011;
  localparam logic [4:0] OP_SEQ   = 5'b11100;
  localparam logic [4:0] OP_SLT   = 5'b11101;
  localparam logic [4:0] OP_SLE   = 5'b11110;
  localparam logic [4:0] OP_SCO   = 5'b11111;

  localparam int         ISA_TAG_W = 3;
  localparam logic [2:0] LINK_REG  = 3'd7;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // Younger stage wins: EX/MEM holds the most recent value of the register.
  function automatic fwd_sel_t youngest_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)  return FWD_EXMEM;
    if (hit_mem) return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_field_decode.sv
// Combinational extraction of source/destination register tags from a
// 16-bit instruction; absent operands are flagged by their valid bits.
module hazard_field_decode
  import hazard_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic [15:0]      instr_i,
  output logic             src1_vld_o,
  output logic [REG_W-1:0] src1_o,
  output logic             src2_vld_o,
  output logic [REG_W-1:0] src2_o,
  output logic             dest_vld_o,
  output logic [REG_W-1:0] dest_o,
  output logic             is_load_o
);

  logic [4:0]           op;
  logic [ISA_TAG_W-1:0] rs, rt, rd;
  logic                 unused_bits;

  assign op          = instr_i[15:11];
  assign rs          = instr_i[10:8];
  assign rt          = instr_i[7:5];
  assign rd          = instr_i[4:2];
  assign unused_bits = ^instr_i[1:0];

  always_comb begin
    src1_vld_o = 1'b1;
    src1_o     = REG_W'(rs);
    src2_vld_o = 1'b0;
    src2_o     = REG_W'(rt);
    dest_vld_o = 1'b0;
    dest_o     = '0;
    is_load_o  = 1'b0;
    unique case (op)
      OP_HALT, OP_NOP, OP_J: begin
        src1_vld_o = 1'b0;
      end
      OP_LBI: begin
        src1_vld_o = 1'b0;
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(rs);
      end
      OP_SLBI: begin
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(rs);
      end
      OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
      OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(rt);
      end
      OP_LD: begin
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(rt);
        is_load_o  = 1'b1;
      end
      OP_ST: begin
        src2_vld_o = 1'b1;
      end
      OP_STU: begin
        src2_vld_o = 1'b1;
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(rs);
      end
      OP_BTR: begin
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(rd);
      end
      OP_SHF, OP_ALU, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
        src2_vld_o = 1'b1;
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(rd);
      end
      OP_JAL: begin
        src1_vld_o = 1'b0;
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(LINK_REG);
      end
      OP_JALR: begin
        dest_vld_o = 1'b1;
        dest_o     = REG_W'(LINK_REG);
      end
      default: begin
        // branches, JR and unassigned opcodes read only the first source
      end
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard detector: shift-register scoreboard of in-flight
// destinations, stall generation, registered EX bypass selects, stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W     = 3,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      id_instr,
  input  logic             id_valid,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } entry_t;

  logic             src1_vld, src2_vld, dest_vld, is_load;
  logic [REG_W-1:0] src1, src2, dest;

  hazard_field_decode #(
    .REG_W(REG_W)
  ) u_decode (
    .instr_i   (id_instr),
    .src1_vld_o(src1_vld),
    .src1_o    (src1),
    .src2_vld_o(src2_vld),
    .src2_o    (src2),
    .dest_vld_o(dest_vld),
    .dest_o    (dest),
    .is_load_o (is_load)
  );

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           ent0_d;
  logic [DEPTH-1:0] m1, m2, lim_mask;
  logic             hz_fwd, hz_leg, hazard, issue;
  fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign m1[k]       = src1_vld & ent_q[k].vld & (ent_q[k].dest == src1);
    assign m2[k]       = src2_vld & ent_q[k].vld & (ent_q[k].dest == src2);
    // With write-before-read regfile the last stage is already visible to ID.
    assign lim_mask[k] = (k < DEPTH - RF_BYPASS);
    if (k == 0) begin : g_head
      assign ent_d[k] = ent0_d;
    end else begin : g_tail
      assign ent_d[k] = ent_q[k-1];
    end
  end

  assign hz_fwd = (m1[0] | m2[0]) & ent_q[0].is_load;
  assign hz_leg = |((m1 | m2) & lim_mask);
  assign hazard = (FWD_EN != 0) ? hz_fwd : hz_leg;

  assign stall = id_valid & ~flush & hazard;
  assign issue = id_valid & ~flush & ~stall;

  always_comb begin
    ent0_d = '0;
    if (issue) begin
      ent0_d.vld     = dest_vld;
      ent0_d.dest    = dest;
      ent0_d.is_load = is_load;
    end
  end

  assign fwd_a_d = (issue && FWD_EN != 0) ? youngest_sel(m1[0], m1[1]) : FWD_RF;
  assign fwd_b_d = (issue && FWD_EN != 0) ? youngest_sel(m2[0], m2[1]) : FWD_RF;

  assign cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '{default: '0};
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ent_q   <= ent_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: four parameter variants share one stimulus
// stream and are checked each cycle against a pipeline-history model.
module tb_hazard_scoreboard;

  logic        clk, rst_n, id_valid, flush;
  logic [15:0] id_instr;
  logic        st0, st1, st2, st3;
  logic [1:0]  fa0, fa1, fa2, fa3, fb0, fb1, fb2, fb3;
  logic [15:0] c0, c1;
  logic [1:0]  c2;
  logic [3:0]  c3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard u_fwd (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall(st0), .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall_cnt(c0));
  hazard_scoreboard #(.FWD_EN(0)) u_leg (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall(st1), .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_cnt(c1));
  hazard_scoreboard #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall(st2), .fwd_sel_a(fa2), .fwd_sel_b(fb2), .stall_cnt(c2));
  hazard_scoreboard #(.REG_W(4), .DEPTH(4), .FWD_EN(0), .RF_BYPASS(0), .CNT_W(4)) u_deep (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid), .flush(flush),
    .stall(st3), .fwd_sel_a(fa3), .fwd_sel_b(fb3), .stall_cnt(c3));

  typedef struct packed {
    bit       s1v;
    bit [2:0] s1;
    bit       s2v;
    bit [2:0] s2;
    bit       dv;
    bit [2:0] d;
    bit       ld;
  } fld_t;

  int p_depth[4], p_fwd[4], p_rfb[4], p_max[4];
  // Model: per variant, the last four issued slots (index 0 = EX).
  bit       mv[4][4];
  bit [2:0] md[4][4];
  bit       ml[4][4];
  int       ma[4], mb[4], mc[4];
  bit       es[4];
  fld_t     cur_fd;
  bit       cur_v, cur_f;
  int       n_cmp, n_bad;

  bit [4:0] ops [32] = '{5'b00000, 5'b00001, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                         5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b10000, 5'b10001,
                         5'b10011, 5'b11001, 5'b11011, 5'b11010, 5'b11100, 5'b11101,
                         5'b11110, 5'b11111, 5'b01100, 5'b01101, 5'b01110, 5'b01111,
                         5'b11000, 5'b10010, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                         5'b10001, 5'b10001};

  // Operand usage by instruction class, written from the ISA format table.
  function automatic fld_t fields(input logic [15:0] w);
    fld_t f;
    f     = '0;
    f.s1v = 1'b1;
    f.s1  = w[10:8];
    f.s2  = w[7:5];
    case (w[15:11])
      5'b00000, 5'b00001, 5'b00100: f.s1v = 1'b0;
      5'b11000: begin f.s1v = 1'b0; f.dv = 1'b1; f.d = w[10:8]; end
      5'b10010: begin f.dv = 1'b1; f.d = w[10:8]; end
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin f.dv = 1'b1; f.d = w[7:5]; end
      5'b10001: begin f.dv = 1'b1; f.d = w[7:5]; f.ld = 1'b1; end
      5'b10000: f.s2v = 1'b1;
      5'b10011: begin f.s2v = 1'b1; f.dv = 1'b1; f.d = w[10:8]; end
      5'b11001: begin f.dv = 1'b1; f.d = w[4:2]; end
      5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111:
        begin f.s2v = 1'b1; f.dv = 1'b1; f.d = w[4:2]; end
      5'b00110: begin f.s1v = 1'b0; f.dv = 1'b1; f.d = 3'd7; end
      5'b00111: begin f.dv = 1'b1; f.d = 3'd7; end
      default: ;
    endcase
    return f;
  endfunction

  function automatic int dut(input int i, input int w);
    case (i)
      0: case (w) 0: return int'(st0); 1: return int'(fa0); 2: return int'(fb0); default: return int'(c0); endcase
      1: case (w) 0: return int'(st1); 1: return int'(fa1); 2: return int'(fb1); default: return int'(c1); endcase
      2: case (w) 0: return int'(st2); 1: return int'(fa2); 2: return int'(fb2); default: return int'(c2); endcase
      default: case (w) 0: return int'(st3); 1: return int'(fa3); 2: return int'(fb3); default: return int'(c3); endcase
    endcase
  endfunction

  function automatic int ysel(input int i, input bit sv, input bit [2:0] s);
    if (sv && mv[i][0] && md[i][0] == s) return 1;
    if (sv && mv[i][1] && md[i][1] == s) return 2;
    return 0;
  endfunction

  task automatic chk(input string nm, input int i, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0d, expected %0d", nm, i, a, e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      ma[i] = 0; mb[i] = 0; mc[i] = 0; es[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin mv[i][k] = 1'b0; md[i][k] = '0; ml[i][k] = 1'b0; end
    end
  endtask

  task automatic drive(input logic [15:0] w, input bit v, input bit f);
    bit h, hit;
    id_instr = w; id_valid = v; flush = f;
    cur_fd = fields(w); cur_v = v; cur_f = f;
    #1;
    for (int i = 0; i < 4; i++) begin
      h = 1'b0;
      for (int k = 0; k < p_depth[i]; k++) begin
        hit = mv[i][k] && ((cur_fd.s1v && md[i][k] == cur_fd.s1) ||
                           (cur_fd.s2v && md[i][k] == cur_fd.s2));
        if (p_fwd[i] != 0) begin
          if (k == 0 && hit && ml[i][0]) h = 1'b1;
        end else if (hit && k < p_depth[i] - p_rfb[i]) h = 1'b1;
      end
      es[i] = v && !f && h;
      chk("stall", i, dut(i, 0), int'(es[i]));
      chk("fwd_sel_a", i, dut(i, 1), ma[i]);
      chk("fwd_sel_b", i, dut(i, 2), mb[i]);
      chk("stall_cnt", i, dut(i, 3), mc[i]);
    end
  endtask

  task automatic tick();
    bit issue;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      issue = cur_v && !cur_f && !es[i];
      ma[i] = (issue && p_fwd[i] != 0) ? ysel(i, cur_fd.s1v, cur_fd.s1) : 0;
      mb[i] = (issue && p_fwd[i] != 0) ? ysel(i, cur_fd.s2v, cur_fd.s2) : 0;
      for (int k = 3; k > 0; k--) begin
        mv[i][k] = mv[i][k-1]; md[i][k] = md[i][k-1]; ml[i][k] = ml[i][k-1];
      end
      mv[i][0] = issue && cur_fd.dv;
      md[i][0] = cur_fd.d;
      ml[i][0] = cur_fd.ld;
      if (es[i] && mc[i] < p_max[i]) mc[i]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      chk("rst_stall", i, dut(i, 0), 0);
      chk("rst_fwd_a", i, dut(i, 1), 0);
      chk("rst_fwd_b", i, dut(i, 2), 0);
      chk("rst_cnt", i, dut(i, 3), 0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit [2:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
  endfunction

  function automatic logic [15:0] rand_instr();
    return {ops[$urandom_range(0, 31)], rreg(), rreg(), rreg(), 2'($urandom_range(0, 3))};
  endfunction

  localparam logic [15:0] I_ADDI = {5'b01000, 3'd2, 3'd1, 5'd5};        // ADDI r1,r2,5
  localparam logic [15:0] I_ADD  = {5'b11011, 3'd1, 3'd4, 3'd3, 2'b00}; // ADD r3,r1,r4
  localparam logic [15:0] I_LD   = {5'b10001, 3'd2, 3'd1, 5'd0};        // LD r1,r2,0
  localparam logic [15:0] I_ADD2 = {5'b11011, 3'd1, 3'd1, 3'd3, 2'b00}; // ADD r3,r1,r1
  localparam logic [15:0] I_SUB  = {5'b11011, 3'd1, 3'd6, 3'd5, 2'b01}; // SUB r5,r1,r6
  localparam logic [15:0] I_ST   = {5'b10000, 3'd1, 3'd1, 5'd0};        // ST r1,r1,0
  localparam logic [15:0] I_JAL  = {5'b00110, 11'd4};
  localparam logic [15:0] I_JR7  = {5'b00101, 3'd7, 8'd0};
  localparam logic [15:0] I_LBI  = {5'b11000, 3'd7, 8'd3};              // LBI r7,3

  initial begin
    logic [15:0] w;
    bit v, f;
    p_depth = '{3, 3, 3, 4};
    p_fwd   = '{1, 0, 1, 0};
    p_rfb   = '{1, 1, 1, 0};
    p_max   = '{65535, 65535, 3, 15};
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b1; id_valid = 1'b0; flush = 1'b0; id_instr = '0;
    cur_fd = '0; cur_v = 1'b0; cur_f = 1'b0;
    #2;
    do_reset();

    drive(I_ADDI, 1, 0); tick();
    drive(I_ADD, 1, 0);  chk("lit_alu_stall", 0, int'(st0), 0); tick();
    chk("lit_alu_fa", 0, int'(fa0), 1); chk("lit_alu_fb", 0, int'(fb0), 0);

    do_reset();
    drive(I_LD, 1, 0);   tick();
    drive(I_ADD2, 1, 0); chk("lit_ld_stall", 0, int'(st0), 1); tick();
    chk("lit_ld_cnt", 0, int'(c0), 1);
    drive(I_ADD2, 1, 0); chk("lit_ld_stall2", 0, int'(st0), 0); tick();
    chk("lit_ld_fa", 0, int'(fa0), 2); chk("lit_ld_fb", 0, int'(fb0), 2);

    do_reset();
    drive(I_ADDI, 1, 0); tick();
    drive(I_SUB, 1, 0);  chk("lit_leg_st1", 1, int'(st1), 1); tick();
    drive(I_SUB, 1, 0);  chk("lit_leg_st2", 1, int'(st1), 1); tick();
    drive(I_SUB, 1, 0);  chk("lit_leg_st3", 1, int'(st1), 0); tick();
    chk("lit_leg_fa", 1, int'(fa1), 0); chk("lit_leg_cnt", 1, int'(c1), 2);

    do_reset();
    drive(I_LD, 1, 0); tick();
    drive(I_ST, 1, 1); chk("lit_flush_stall", 0, int'(st0), 0); tick();
    chk("lit_flush_cnt", 0, int'(c0), 0); chk("lit_flush_fa", 0, int'(fa0), 0);
    drive(I_ST, 1, 0); chk("lit_st_stall", 0, int'(st0), 0); tick();
    chk("lit_st_fa", 0, int'(fa0), 2); chk("lit_st_fb", 0, int'(fb0), 2);

    do_reset();
    drive(I_JAL, 1, 0); tick();
    drive(I_JR7, 1, 0); tick();
    chk("lit_jr_fa", 0, int'(fa0), 1);
    drive(I_JAL, 1, 0); tick();
    drive(I_LBI, 1, 0); tick();
    drive(I_JR7, 1, 0); tick();
    chk("lit_young_fa", 0, int'(fa0), 1);

    do_reset();
    repeat (5) begin
      drive(I_LD, 1, 0);   tick();
      drive(I_ADD2, 1, 0); tick();
    end
    chk("lit_sat_cnt", 2, int'(c2), 3);
    drive(I_LD, 1, 0);   tick();
    drive(I_ADD2, 1, 0); chk("lit_sat_stall", 2, int'(st2), 1);
    #1;
    do_reset();
    drive(I_ADD2, 1, 0); chk("lit_post_rst_stall", 2, int'(st2), 0); tick();

    w = rand_instr();
    repeat (1500) begin
      if (!(es[0] && $urandom_range(0, 9) < 7)) w = rand_instr();
      v = ($urandom_range(0, 9) != 0);
      f = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      drive(w, v, f);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
